seven_seg_scanner: RTL and testbench

Parametrised multiplexed seven-segment scanner for N common-cathode digits, sitting between the display-data producers and the board's segment/select pins. It scans digits MSB-first and adds tear-free frame-synchronous data loading, per-digit enable, decimal points, leading-zero suppression, PWM brightness and inter-digit ghost blanking. Segments and selects are fully registered and aligned at the pins.

---
 rtl/seven_seg_scanner_pkg.sv | 46 ++++
 rtl/seven_seg_scanner_if.sv | 22 ++
 rtl/seven_seg_scanner_hex_to_7seg.sv | 33 +++
 rtl/seven_seg_scanner.sv | 202 ++++++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants and helpers for the seven-segment scanner.
// Segment patterns are packed {g,f,e,d,c,b,a}, with 1 meaning the segment is lit.
package seven_seg_pkg;

  localparam int MAX_DIGITS = 16;

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] HEX_0   = 7'h3F;
  localparam logic [6:0] HEX_1   = 7'h06;
  localparam logic [6:0] HEX_2   = 7'h5B;
  localparam logic [6:0] HEX_3   = 7'h4F;
  localparam logic [6:0] HEX_4   = 7'h66;
  localparam logic [6:0] HEX_5   = 7'h6D;
  localparam logic [6:0] HEX_6   = 7'h7D;
  localparam logic [6:0] HEX_7   = 7'h07;
  localparam logic [6:0] HEX_8   = 7'h7F;
  localparam logic [6:0] HEX_9   = 7'h6F;
  localparam logic [6:0] HEX_A   = 7'h77;
  localparam logic [6:0] HEX_B   = 7'h7C;
  localparam logic [6:0] HEX_C   = 7'h39;
  localparam logic [6:0] HEX_D   = 7'h5E;
  localparam logic [6:0] HEX_E   = 7'h79;
  localparam logic [6:0] HEX_F   = 7'h71;

  // Leading-zero mask: walk from the leftmost digit (n-1) toward digit 1 and
  // flag every zero nibble until the first nonzero one. Digit 0 is never flagged
  // so an all-zero value still shows a single "0".
  function automatic logic [MAX_DIGITS-1:0] lz_mask_f(input logic [4*MAX_DIGITS-1:0] d,
                                                      input int n);
    logic [MAX_DIGITS-1:0] m;
    logic                  run;
    m   = '0;
    run = 1'b1;
    for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
      if (k < n) begin
        if (run && (d[4*k +: 4] == 4'h0)) begin
          m[k] = 1'b1;
        end else begin
          run = 1'b0;
        end
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Producer-side bus of the scanner: display data, controls and the frame strobe.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load;
  logic                    lz_suppress;
  logic [3:0]              brightness;
  logic                    frame_done;

  modport master (
    output digits, dp_in, digit_en, load, lz_suppress, brightness,
    input  frame_done
  );

  modport slave (
    input  digits, dp_in, digit_en, load, lz_suppress, brightness,
    output frame_done
  );
endinterface

// File: rtl/seven_seg_scanner_hex_to_7seg.sv
// Combinational hex nibble to seven-segment pattern decoder.
module hex_to_7seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the standard hex glyphs
  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = HEX_0;
      4'h1: seg = HEX_1;
      4'h2: seg = HEX_2;
      4'h3: seg = HEX_3;
      4'h4: seg = HEX_4;
      4'h5: seg = HEX_5;
      4'h6: seg = HEX_6;
      4'h7: seg = HEX_7;
      4'h8: seg = HEX_8;
      4'h9: seg = HEX_9;
      4'hA: seg = HEX_A;
      4'hB: seg = HEX_B;
      4'hC: seg = HEX_C;
      4'hD: seg = HEX_D;
      4'hE: seg = HEX_E;
      4'hF: seg = HEX_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner for common-cathode digits.
// Scans leftmost digit first, swaps in new data only at frame boundaries,
// and registers segments and selects together at the pins.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_BITS   = 16,
  parameter int BLANK_CYCLES   = 64,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  seven_seg_scanner_if.slave    bus,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [NUM_DIGITS-1:0] digit_sel
);

  localparam int                      IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [REFRESH_BITS-1:0] SLOT_MAX = '1;
  localparam logic [REFRESH_BITS-1:0] SLOT_PRE = SLOT_MAX - REFRESH_BITS'(1);
  localparam logic [REFRESH_BITS-1:0] BLANK    = REFRESH_BITS'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]        IDX_TOP  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]              SEG_RST  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : SEG_OFF;
  localparam logic                    DP_RST   = (SEG_ACTIVE_LOW != 0);

  function automatic logic [6:0] seg_pol(input logic [6:0] s);
    return (SEG_ACTIVE_LOW != 0) ? ~s : s;
  endfunction

  function automatic logic dp_pol(input logic d);
    return (SEG_ACTIVE_LOW != 0) ? ~d : d;
  endfunction

  logic [REFRESH_BITS-1:0]  slot_cnt;
  logic [IDX_W-1:0]         idx;
  logic                     frame_q;
  logic                     slot_wrap;
  logic                     boundary;

  logic [4*NUM_DIGITS-1:0]  staging_dig;
  logic [NUM_DIGITS-1:0]    staging_dp;
  logic                     pending;
  logic [4*NUM_DIGITS-1:0]  shadow_dig;
  logic [NUM_DIGITS-1:0]    shadow_dp;
  logic [NUM_DIGITS-1:0]    lz_mask;
  logic [4*NUM_DIGITS-1:0]  next_dig;
  logic [NUM_DIGITS-1:0]    next_dp;
  logic [4*MAX_DIGITS-1:0]  lz_src;
  logic [MAX_DIGITS-1:0]    lz_full;
  logic                     unused_lz;

  logic [3:0]               nib_sel;
  logic                     dp_sel;
  logic                     supp_sel;
  logic                     en_sel;
  logic                     lit_sel;

  logic                     lit_p0;
  logic [3:0]               nib_p0;
  logic                     dp_p0;
  logic                     supp_p0;
  logic [IDX_W-1:0]         idx_p0;
  logic [6:0]               seg_dec;

  logic                     lit_p1;
  logic [6:0]               seg_p1;
  logic                     dp_p1;
  logic [IDX_W-1:0]         idx_p1;
  logic [NUM_DIGITS-1:0]    sel_nxt;

  assign slot_wrap      = (slot_cnt == SLOT_MAX);
  assign boundary       = slot_wrap && (idx == '0);
  assign bus.frame_done = frame_q;

  // Slot counter, digit index stepping leftmost-first, and the frame strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt <= '0;
      idx      <= IDX_TOP;
      frame_q  <= 1'b0;
    end else begin
      slot_cnt <= slot_cnt + REFRESH_BITS'(1);
      if (slot_wrap) begin
        idx <= (idx == '0) ? IDX_TOP : idx - IDX_W'(1);
      end
      // registered one cycle early so the pulse coincides with the boundary cycle
      frame_q <= (slot_cnt == SLOT_PRE) && (idx == '0);
    end
  end

  // Value the shadow takes at the boundary, and its leading-zero mask
  always_comb begin
    next_dig = pending ? staging_dig : shadow_dig;
    next_dp  = pending ? staging_dp  : shadow_dp;
    lz_src   = '0;
    lz_src[4*NUM_DIGITS-1:0] = next_dig;
    lz_full   = lz_mask_f(lz_src, NUM_DIGITS);
    unused_lz = ^lz_full;
  end

  // Staging captures every load; shadow only changes at a frame boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging_dig <= '0;
      staging_dp  <= '0;
      pending     <= 1'b0;
      shadow_dig  <= '0;
      shadow_dp   <= '0;
      lz_mask     <= '0;
    end else begin
      if (bus.load) begin
        staging_dig <= bus.digits;
        staging_dp  <= bus.dp_in;
      end
      if (boundary) begin
        shadow_dig <= next_dig;
        shadow_dp  <= next_dp;
        lz_mask    <= bus.lz_suppress ? lz_full[NUM_DIGITS-1:0] : '0;
      end
      // a load in the boundary cycle stays pending for the following frame
      if (bus.load) begin
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

  // Select the current digit's data and decide whether this slot cycle is lit
  always_comb begin
    nib_sel  = 4'h0;
    dp_sel   = 1'b0;
    supp_sel = 1'b0;
    en_sel   = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        nib_sel  = shadow_dig[4*k +: 4];
        dp_sel   = shadow_dp[k];
        supp_sel = lz_mask[k];
        en_sel   = bus.digit_en[k];
      end
    end
    lit_sel = (slot_cnt >= BLANK) &&
              (slot_cnt[REFRESH_BITS-1 -: 4] <= bus.brightness) &&
              en_sel;
  end

  // ---- stage p0: nibble mux / stage p1: decode (lit flags) ----
  // Lit flags are control and must restart dark after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lit_p0 <= 1'b0;
      lit_p1 <= 1'b0;
    end else begin
      lit_p0 <= lit_sel;
      lit_p1 <= lit_p0;
    end
  end

  hex_to_7seg u_dec (
    .nibble (nib_p0),
    .seg    (seg_dec)
  );

  // Data side of stages p0 and p1; always gated by the lit flags downstream
  always_ff @(posedge clk) begin
    nib_p0  <= nib_sel;
    dp_p0   <= dp_sel;
    supp_p0 <= supp_sel;
    idx_p0  <= idx;
    seg_p1  <= supp_p0 ? SEG_OFF : seg_dec;
    dp_p1   <= dp_p0;
    idx_p1  <= idx_p0;
  end

  // Active-low one-hot select for the digit being shown
  always_comb begin
    sel_nxt = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (lit_p1 && (idx_p1 == IDX_W'(k))) begin
        sel_nxt[k] = 1'b0;
      end
    end
  end

  // ---- stage p2: output registers at the pins ----
  // Segments, dp and selects update together; reset darkens them at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_out   <= SEG_RST;
      dp_out    <= DP_RST;
      digit_sel <= '1;
    end else begin
      seg_out   <= seg_pol(lit_p1 ? seg_p1 : SEG_OFF);
      dp_out    <= dp_pol(lit_p1 && dp_p1);
      digit_sel <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with 4 digits, 64-cycle slots, 4 blank cycles.
// A slot_cnt value m reaches the pins after clock edge m+3, counted from reset release.
module tb_seven_seg_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [3:0] digit_sel;
  int         checks = 0;
  int         errors = 0;
  int         cyc;
  int         lit_cnt;
  int         bad_sel;
  int         dp_seen;

  seven_seg_scanner_if #(.NUM_DIGITS(4)) bus ();

  seven_seg_scanner #(
    .NUM_DIGITS     (4),
    .REFRESH_BITS   (6),
    .BLANK_CYCLES   (4),
    .SEG_ACTIVE_LOW (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .digit_sel (digit_sel)
  );

  always #5 clk = ~clk;

  // edges since reset release
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_to(input int n);
    if (cyc > n) check("schedule", cyc, n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic expect_pins(input string tag, input int n,
                             input logic [6:0] seg, input logic [3:0] sel);
    wait_to(n);
    check({tag, "_seg"}, seg_out, seg);
    check({tag, "_sel"}, digit_sel, sel);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    bus.digits  = d;
    bus.dp_in   = dp;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load    = 1'b0;
  endtask

  task automatic count_lit(input int a, input int b, output int c);
    c = 0;
    wait_to(a);
    while (cyc <= b) begin
      if (digit_sel != 4'hF) c++;
      @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.digits      = 16'h0000;
    bus.dp_in       = 4'h0;
    bus.digit_en    = 4'hF;
    bus.load        = 1'b0;
    bus.lz_suppress = 1'b0;
    bus.brightness  = 4'd15;

    repeat (3) @(negedge clk);
    check("rst_seg", seg_out, 7'h00);
    check("rst_dp", dp_out, 1'b0);
    check("rst_sel", digit_sel, 4'hF);
    check("rst_fd", bus.frame_done, 1'b0);
    reset = 1'b0;

    // first lit cycle: slot_cnt 4 shows at edge 7
    expect_pins("blank", 6, 7'h00, 4'hF);
    expect_pins("first_lit", 7, 7'h3F, 4'h7);

    // staged load is invisible until the first boundary
    wait_to(20);
    do_load(16'h12AF, 4'h0);
    expect_pins("pre_bnd", 100, 7'h3F, 4'hB);
    wait_to(254); check("fd_254", bus.frame_done, 1'b0);
    wait_to(255); check("fd_255", bus.frame_done, 1'b1);
    wait_to(256); check("fd_256", bus.frame_done, 1'b0);
    expect_pins("d3_1", 269, 7'h06, 4'h7);
    check("d3_dp", dp_out, 1'b0);
    expect_pins("d2_2", 333, 7'h5B, 4'hB);
    expect_pins("d1_A", 397, 7'h77, 4'hD);
    expect_pins("d0_F", 461, 7'h71, 4'hE);

    // leading-zero suppression
    wait_to(470);
    bus.lz_suppress = 1'b1;
    do_load(16'h0005, 4'h0);
    expect_pins("lz5_d3", 525, 7'h00, 4'h7);
    expect_pins("lz5_d2", 589, 7'h00, 4'hB);
    expect_pins("lz5_d1", 653, 7'h00, 4'hD);
    expect_pins("lz5_d0", 717, 7'h6D, 4'hE);
    wait_to(730);
    do_load(16'h0000, 4'h0);
    expect_pins("lz0_d3", 781, 7'h00, 4'h7);

    // two loads in one frame: only the last one lands, at the boundary
    wait_to(800);
    bus.lz_suppress = 1'b0;
    do_load(16'h1111, 4'h0);
    expect_pins("tear_d2", 845, 7'h00, 4'hB);
    wait_to(900);
    do_load(16'h2222, 4'h0);
    expect_pins("lz0_d0", 973, 7'h3F, 4'hE);
    expect_pins("tear_pre", 1013, 7'h3F, 4'hE);
    wait_to(1023); check("fd_1023", bus.frame_done, 1'b1);
    expect_pins("tear_d3", 1037, 7'h5B, 4'h7);
    expect_pins("tear_d0", 1229, 7'h5B, 4'hE);

    // brightness window
    wait_to(1240);
    bus.brightness = 4'd1;
    expect_pins("br1_pre", 1286, 7'h00, 4'hF);
    expect_pins("br1_on", 1287, 7'h5B, 4'h7);
    expect_pins("br1_last", 1290, 7'h5B, 4'h7);
    expect_pins("br1_off", 1291, 7'h00, 4'hF);
    count_lit(1347, 1410, lit_cnt);
    check("br1_count", lit_cnt, 4);
    wait_to(1415);
    bus.brightness = 4'd0;
    count_lit(1475, 1538, lit_cnt);
    check("br0_count", lit_cnt, 0);
    wait_to(1540);
    bus.brightness = 4'd15;
    count_lit(1603, 1666, lit_cnt);
    check("br15_count", lit_cnt, 60);

    // digit enable and decimal point
    wait_to(1670);
    bus.digit_en = 4'b1010;
    do_load(16'h2222, 4'b0001);
    wait_to(1795);
    lit_cnt = 0; bad_sel = 0; dp_seen = 0;
    while (cyc <= 2050) begin
      if (digit_sel != 4'hF) lit_cnt++;
      if (digit_sel[2] == 1'b0 || digit_sel[0] == 1'b0) bad_sel++;
      if (dp_out) dp_seen++;
      @(negedge clk);
    end
    check("en_lit_count", lit_cnt, 120);
    check("en_bad_sel", bad_sel, 0);
    check("en_dp_seen", dp_seen, 0);
    wait_to(2060);
    bus.digit_en = 4'hF;
    expect_pins("dp_d0", 2253, 7'h5B, 4'hE);
    check("dp_d0_dp", dp_out, 1'b1);

    // reset during a lit slot drops a staged load
    wait_to(2255);
    do_load(16'h8888, 4'h0);
    expect_pins("pre_rst", 2260, 7'h5B, 4'hE);
    reset = 1'b1;
    #1;
    check("arst_seg", seg_out, 7'h00);
    check("arst_sel", digit_sel, 4'hF);
    check("arst_dp", dp_out, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_seg", seg_out, 7'h00);
    check("hold_sel", digit_sel, 4'hF);
    reset = 1'b0;
    expect_pins("rel_first", 7, 7'h3F, 4'h7);
    expect_pins("rel_lost", 269, 7'h3F, 4'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
